gray_counter: RTL and testbench
===============================

# gray_counter

Parametrised up/down counter that holds its state in binary and presents binary and Gray-coded outputs together, registered on the same edge. It extends the team's combinational 4-bit binary-to-Gray converter into a sequential, width-generic block. Intended uses are clock-domain-crossing pointers, rotary and position sequencing, and stimulus generation. It supports synchronous load of either a binary or a Gray-encoded value and flags wrap-around.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- RESET_VAL, 0, binary value loaded on reset; must be < 2^WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe; overrides en.
- load_gray  input  1  1 = load_val is Gray-encoded, 0 = load_val is binary.
- load_val  input  WIDTH  value to load.
- bin_q  output  WIDTH  registered binary count.
- gray_q  output  WIDTH  registered Gray code of bin_q.
- wrap  output  1  registered one-cycle pulse; high when the last step crossed the max/0 boundary.

## Operation
- Internal state is the binary count. gray_q is always gray(bin_q), where gray(x) = x ^ (x >> 1).
- gray_q must be produced from the next-state value and registered, not decoded combinationally from bin_q.
- Gray-to-binary conversion for a load: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], for i = WIDTH-2 down to 0.
- Priority per rising edge:
  1. load=1: bin_q ← load_gray ? g2b(load_val) : load_val. wrap ← 0. en and up are ignored.
  2. load=0, en=1, up=1: bin_q ← bin_q + 1, modulo 2^WIDTH. wrap ← 1 iff bin_q was 2^WIDTH−1.
  3. load=0, en=1, up=0: bin_q ← bin_q − 1, modulo 2^WIDTH. wrap ← 1 iff bin_q was 0.
  4. load=0, en=0: bin_q holds; wrap ← 0.
- Arithmetic is unsigned, WIDTH bits. The carry/borrow is used only for wrap and is never stored.
- Direction may change on any cycle with no idle cycle needed; the step follows the up value sampled on that edge.
- Between consecutive non-load cycles, gray_q changes in exactly one bit, or in none when holding. This also holds across wrap in both directions.
- A load may change any number of bits of gray_q.

## Timing
- Reset (rst_n=0, asynchronous assert): bin_q = RESET_VAL, gray_q = gray(RESET_VAL), wrap = 0, all immediately without waiting for a clock edge.
- Reset release is synchronous in effect: the first count or load happens on the first rising edge that samples rst_n=1.
- Latency: control inputs sampled at edge N are reflected on bin_q, gray_q and wrap after edge N. That is one cycle, with no pipeline skew between the three outputs.
- wrap is high for exactly one cycle per boundary crossing. During continuous counting of a full range it pulses once every 2^WIDTH cycles.
- Reset asserted mid-count aborts the count, with no partial step. A pending wrap pulse is cleared.
- If load and en are high together, the load wins, and the loaded value is not stepped in the same cycle.

## Test plan
- Reset and up-count, WIDTH=4, RESET_VAL=0: release rst_n, hold en=1 and up=1 for 16 cycles.
  - Required: gray_q = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - Required: wrap high only on the cycle bin_q returns from 1111 to 0000.
  - Required: each gray_q step differs from the previous one in exactly one bit.
- Down-count wrap: starting at bin_q = 0000, set en=1, up=0.
  - Required: bin_q = 1111, gray_q = 1000, wrap = 1 for one cycle.
  - Then: bin_q = 1110, gray_q = 1001, wrap = 0.
- Gray load: load=1, load_gray=1, load_val=1101.
  - Required: next cycle bin_q = 1001, gray_q = 1101, wrap = 0.
  - Repeat with load_gray=0, load_val=1101: required bin_q = 1101, gray_q = 1011.
- Simultaneous load and count: load=1, en=1, up=1, load_gray=0, load_val=0111.
  - Required: bin_q = 0111, not 1000.
  - Next cycle, with load=0: required bin_q = 1000, gray_q = 1100.
- Asynchronous reset mid-count: with RESET_VAL=5, assert rst_n=0 between clock edges while counting.
  - Required: bin_q = 0101, gray_q = 0111, wrap = 0 before the next edge.
  - Required: outputs hold while in reset and resume counting from 0101 after release.
- Width scaling, WIDTH=8: count up from 0xFE for 3 cycles.
  - Required: bin_q = FF, 00, 01 and gray_q = 80, 00, 01.
  - Required: wrap only on the FF-to-00 step.

Source files
------------

// File: rtl/gray_counter_if.sv
// Control and result bundle for gray_counter.
// master drives the controls, slave returns the registered counts.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic             load_gray;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap;

  modport master (
    output en, up, load, load_gray, load_val,
    input  bin_q, gray_q, wrap
  );

  modport slave (
    input  en, up, load, load_gray, load_val,
    output bin_q, gray_q, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Width-generic up/down counter with binary and Gray outputs.
// Binary and Gray registers load from the same next-state value.
module gray_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input logic          clk,
  input logic          rst_n,
  gray_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] g2b;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;

  // Top bit of the widened sum/difference is the carry/borrow.
  assign inc = {1'b0, bin_r} + {{WIDTH{1'b0}}, 1'b1};
  assign dec = {1'b0, bin_r} - {{WIDTH{1'b0}}, 1'b1};

  // Each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    g2b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g2b[i] = ^(bus.load_val >> i);
    end
  end

  always_comb begin
    bin_nxt  = bin_r;
    wrap_nxt = 1'b0;
    unique case (1'b1)
      bus.load: begin
        bin_nxt = bus.load_gray ? g2b : bus.load_val;
      end
      (!bus.load && bus.en && bus.up): begin
        bin_nxt  = inc[WIDTH-1:0];
        wrap_nxt = inc[WIDTH];
      end
      (!bus.load && bus.en && !bus.up): begin
        bin_nxt  = dec[WIDTH-1:0];
        wrap_nxt = dec[WIDTH];
      end
      default: begin
        bin_nxt  = bin_r;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= RST_BIN;
      gray_r <= RST_GRAY;
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= bin_nxt;
      gray_r <= bin_nxt ^ (bin_nxt >> 1);
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.bin_q  = bin_r;
  assign bus.gray_q = gray_r;
  assign bus.wrap   = wrap_r;
endmodule

// File: tb/tb_gray_counter.sv
// Random and directed bench for gray_counter at two widths.
// An arithmetic reference model is checked on every falling edge.
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_on = 1'b0;
  bit   b_done = 1'b0;
  bit   c_done = 1'b0;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(4)) ia ();
  gray_counter_if #(.WIDTH(4)) ib ();
  gray_counter_if #(.WIDTH(8)) ic ();

  gray_counter #(.WIDTH(4), .RESET_VAL(0)) u_a (
    .clk(clk), .rst_n(rst_a), .bus(ia)
  );
  gray_counter #(.WIDTH(4), .RESET_VAL(5)) u_b (
    .clk(clk), .rst_n(rst_b), .bus(ib)
  );
  gray_counter #(.WIDTH(8), .RESET_VAL(0)) u_c (
    .clk(clk), .rst_n(rst_c), .bus(ic)
  );

  function automatic logic [31:0] gray32(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] g2b32(input logic [31:0] g, input int w);
    logic [31:0] b;
    logic [31:0] m;
    b = 32'd0;
    for (int k = 0; k < w; k++) b = b ^ (g >> k);
    m = 32'((64'd1 << w) - 64'd1);
    return b & m;
  endfunction

  task automatic step(input int w, input logic [31:0] cur,
                      input logic ld, input logic lg,
                      input logic [31:0] lv, input logic en,
                      input logic up, output logic [31:0] nxt,
                      output logic wr);
    longint unsigned m;
    longint unsigned c;
    m = 64'd1 << w;
    c = 64'(cur);
    if (ld) begin
      nxt = lg ? g2b32(lv, w) : lv;
      wr  = 1'b0;
    end else if (en && up) begin
      nxt = 32'((c + 64'd1) % m);
      wr  = (c == m - 64'd1);
    end else if (en) begin
      nxt = 32'((c + m - 64'd1) % m);
      wr  = (c == 64'd0);
    end else begin
      nxt = cur;
      wr  = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  logic [31:0] ma, mb, mc;
  logic        mwa, mwb, mwc;
  logic [31:0] pa, pc;
  bit          ka, kc;
  logic        ea, ec;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ma = 32'd0; mwa = 1'b0; ka = 1'b0;
    end else begin
      pa = gray32(ma); ka = !ia.load; ea = ia.en;
      step(4, ma, ia.load, ia.load_gray, 32'(ia.load_val),
           ia.en, ia.up, ma, mwa);
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mb = 32'd5; mwb = 1'b0;
    end else begin
      step(4, mb, ib.load, ib.load_gray, 32'(ib.load_val),
           ib.en, ib.up, mb, mwb);
    end
  end

  always @(posedge clk or negedge rst_c) begin
    if (!rst_c) begin
      mc = 32'd0; mwc = 1'b0; kc = 1'b0;
    end else begin
      pc = gray32(mc); kc = !ic.load; ec = ic.en;
      step(8, mc, ic.load, ic.load_gray, 32'(ic.load_val),
           ic.en, ic.up, mc, mwc);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_bin", 32'(ia.bin_q), ma);
      chk("a_gray", 32'(ia.gray_q), gray32(ma));
      chk("a_wrap", 32'(ia.wrap), 32'(mwa));
      if (ka)
        chk("a_1bit", 32'($countones(ia.gray_q ^ 4'(pa))),
            ea ? 32'd1 : 32'd0);
      chk("b_bin", 32'(ib.bin_q), mb);
      chk("b_gray", 32'(ib.gray_q), gray32(mb));
      chk("b_wrap", 32'(ib.wrap), 32'(mwb));
      chk("c_bin", 32'(ic.bin_q), mc);
      chk("c_gray", 32'(ic.gray_q), gray32(mc));
      chk("c_wrap", 32'(ic.wrap), 32'(mwc));
      if (kc)
        chk("c_1bit", 32'($countones(ic.gray_q ^ 8'(pc))),
            ec ? 32'd1 : 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Walking Gray sequence for a full 4-bit up-count from zero.
  int tbl [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14,
                   10, 11, 9, 8, 0};

  initial begin
    ia.en = 0; ia.up = 0; ia.load = 0; ia.load_gray = 0; ia.load_val = '0;
    ib.en = 0; ib.up = 0; ib.load = 0; ib.load_gray = 0; ib.load_val = '0;
    ic.en = 0; ic.up = 0; ic.load = 0; ic.load_gray = 0; ic.load_val = '0;
    #1;
    rst_a = 0; rst_b = 0; rst_c = 0;
    #1;
    chk("rst_a_bin", 32'(ia.bin_q), 32'd0);
    chk("rst_a_wrap", 32'(ia.wrap), 32'd0);
    chk("rst_b_bin", 32'(ib.bin_q), 32'd5);
    chk("rst_b_gray", 32'(ib.gray_q), 32'd7);
    chk("rst_c_gray", 32'(ic.gray_q), 32'd0);
    chk_on = 1'b1;
    @(negedge clk);
    rst_a = 1; rst_b = 1; rst_c = 1;
    ia.en = 1; ia.up = 1;
    chk("up_gray", 32'(ia.gray_q), 32'(tbl[0]));
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("up_gray", 32'(ia.gray_q), 32'(tbl[i]));
      chk("up_wrap", 32'(ia.wrap), (i == 16) ? 32'd1 : 32'd0);
    end
    ia.up = 0;
    @(negedge clk);
    chk("dn_bin", 32'(ia.bin_q), 32'd15);
    chk("dn_gray", 32'(ia.gray_q), 32'd8);
    chk("dn_wrap", 32'(ia.wrap), 32'd1);
    @(negedge clk);
    chk("dn2_bin", 32'(ia.bin_q), 32'd14);
    chk("dn2_gray", 32'(ia.gray_q), 32'd9);
    chk("dn2_wrap", 32'(ia.wrap), 32'd0);
    ia.en = 0; ia.load = 1; ia.load_gray = 1; ia.load_val = 4'b1101;
    @(negedge clk);
    chk("ldg_bin", 32'(ia.bin_q), 32'd9);
    chk("ldg_gray", 32'(ia.gray_q), 32'd13);
    chk("ldg_wrap", 32'(ia.wrap), 32'd0);
    ia.load_gray = 0;
    @(negedge clk);
    chk("ldb_bin", 32'(ia.bin_q), 32'd13);
    chk("ldb_gray", 32'(ia.gray_q), 32'd11);
    ia.en = 1; ia.up = 1; ia.load_val = 4'b0111;
    @(negedge clk);
    chk("ldcnt_bin", 32'(ia.bin_q), 32'd7);
    ia.load = 0;
    @(negedge clk);
    chk("ldnxt_bin", 32'(ia.bin_q), 32'd8);
    chk("ldnxt_gray", 32'(ia.gray_q), 32'd12);
    repeat (2000) begin
      ia.load      = ($urandom_range(7) == 0);
      ia.load_gray = 1'($urandom);
      ia.load_val  = 4'($urandom);
      ia.en        = ($urandom_range(3) != 0);
      ia.up        = 1'($urandom);
      @(negedge clk);
    end
    ia.load = 0; ia.en = 1; ia.up = 1;
    repeat (20) @(negedge clk);
    wait (b_done && c_done);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    @(posedge rst_b);
    ib.en = 1; ib.up = 1;
    repeat (11) @(posedge clk);
    #2;
    chk("b_pre_wrap", 32'(ib.wrap), 32'd1);
    chk("b_pre_bin", 32'(ib.bin_q), 32'd0);
    rst_b = 0;
    #1;
    chk("arst_bin", 32'(ib.bin_q), 32'd5);
    chk("arst_gray", 32'(ib.gray_q), 32'd7);
    chk("arst_wrap", 32'(ib.wrap), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_hold", 32'(ib.bin_q), 32'd5);
    end
    rst_b = 1;
    @(negedge clk);
    chk("arst_resume_bin", 32'(ib.bin_q), 32'd6);
    chk("arst_resume_gray", 32'(ib.gray_q), 32'd5);
    b_done = 1'b1;
  end

  initial begin
    @(posedge rst_c);
    ic.load = 1; ic.load_val = 8'hFE;
    @(negedge clk);
    chk("w8_ld", 32'(ic.bin_q), 32'hFE);
    ic.load = 0; ic.en = 1; ic.up = 1;
    @(negedge clk);
    chk("w8_bin0", 32'(ic.bin_q), 32'hFF);
    chk("w8_gray0", 32'(ic.gray_q), 32'h80);
    chk("w8_wrap0", 32'(ic.wrap), 32'd0);
    @(negedge clk);
    chk("w8_bin1", 32'(ic.bin_q), 32'h00);
    chk("w8_gray1", 32'(ic.gray_q), 32'h00);
    chk("w8_wrap1", 32'(ic.wrap), 32'd1);
    @(negedge clk);
    chk("w8_bin2", 32'(ic.bin_q), 32'h01);
    chk("w8_gray2", 32'(ic.gray_q), 32'h01);
    chk("w8_wrap2", 32'(ic.wrap), 32'd0);
    repeat (2000) begin
      ic.load      = ($urandom_range(15) == 0);
      ic.load_gray = 1'($urandom);
      ic.load_val  = 8'($urandom);
      ic.en        = ($urandom_range(7) != 0);
      ic.up        = ($urandom_range(3) != 0);
      @(negedge clk);
    end
    c_done = 1'b1;
  end
endmodule
